taxi_eth_mac_swap: RTL
======================

TAXI_ETH_MAC_SWAP -- requirements
Module: taxi_eth_mac_swap

Interface
REQ-001 Parameter DATA_W, default 64, AXI-stream data width; only 64 is supported, and any other value SHALL be a elaboration error.
REQ-002 Parameter ID_W, default 8, tid width passed through unchanged.
REQ-003 Parameter USER_W, default 1, tuser width; bit 0 is the bad-frame flag.
REQ-004 clk  input  1  block clock; all logic is synchronous to it.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low; deassertion is synchronised to clk by the instantiating level.
REQ-006 s_axis  taxi_axis_if sink  DATA_W  frames from the MAC RX interface (tdata, tkeep, tvalid, tready, tlast, tid, tuser).
REQ-007 m_axis  taxi_axis_if source  DATA_W  modified frames toward the per-channel async FIFO.
REQ-008 stat_frames  output  32  count of frames whose addresses were swapped (present only with the macro in REQ-030).
REQ-009 stat_short  output  32  count of frames passed unmodified as too short (present only with the macro in REQ-030).

Function
REQ-010 For every frame of at least 12 bytes, the block SHALL exchange destination MAC (bytes 0-5) and source MAC (bytes 6-11); all other bytes, tkeep, tid and tuser SHALL be unchanged.
REQ-011 Output beat 0 byte mapping SHALL be: out bytes 0-5 = in bytes 6-11, and out bytes 6-7 = in bytes 0-1.
REQ-012 Output beat 1 byte mapping SHALL be: out bytes 0-3 = in bytes 2-5, and out bytes 4-7 = in beat 1 bytes 4-7.
REQ-013 The FSM SHALL have three states: HEAD0 (await beat 0), HEAD1 (beat 0 held, await beat 1), and BODY (pass-through until tlast).
REQ-014 HEAD0 SHALL capture beat 0 into a hold register; without tlast it SHALL go to HEAD1, and with tlast the beat SHALL be emitted unmodified (short frame) while remaining in HEAD0.
REQ-015 HEAD1 SHALL combine the hold register with beat 1 and emit modified beat 0, then modified beat 1.
REQ-016 From HEAD1, if beat 1 has tlast set, the FSM SHALL return to HEAD0; otherwise it SHALL go to BODY.
REQ-017 If beat 1 has tkeep[3:0] != 4'hF, the frame is short: both beats SHALL be emitted unmodified and stat_short SHALL increment.
REQ-018 BODY SHALL forward beats unchanged and return to HEAD0 on the accepted tlast beat.
REQ-019 The tuser of the held beat 0 SHALL be replaced by the tuser of beat 1 when that beat has tlast, so that a bad-frame mark reaches every beat.
REQ-020 The output SHALL be registered; m_axis outputs SHALL not depend combinationally on s_axis.
REQ-021 Latency SHALL be 2 cycles from acceptance of beat 1 to m_axis.tvalid for beat 0, and 1 cycle per beat in BODY.
REQ-022 Throughput SHALL be one beat per cycle sustained when m_axis.tready=1; the single bubble from holding beat 0 SHALL be absorbed, not accumulated.
REQ-023 Backpressure: s_axis.tready SHALL deassert only when the hold and output stages are both occupied and m_axis.tready=0.
REQ-024 No beat SHALL be dropped, duplicated or reordered under any tvalid/tready pattern.
REQ-025 A frame ending while the output is stalled SHALL allow the next frame's beat 0 to be captured in the same cycle tlast is accepted.

Reset
REQ-026 On rst_n low: FSM = HEAD0, m_axis.tvalid = 0, s_axis.tready = 0, hold register and outputs = 0, and counters = 0.
REQ-027 s_axis.tready SHALL rise the first cycle after rst_n deasserts.
REQ-028 Reset mid-frame SHALL discard partial frame state; no beat of that frame SHALL appear after reset.
REQ-029 Counters SHALL wrap modulo 2^32 without saturation.

Configuration
REQ-030 Macro TAXI_ETH_MAC_SWAP_STAT_EN: when defined, stat_frames and stat_short ports and counters SHALL exist, each incrementing once per frame on acceptance of the tlast beat.
REQ-031 When TAXI_ETH_MAC_SWAP_STAT_EN is undefined, the ports and counter logic SHALL be absent; the datapath SHALL be identical in both builds.

Structure
REQ-032 Package taxi_eth_mac_swap_pkg SHALL hold the FSM state enum (HEAD0, HEAD1, BODY) and the constants MAC_BYTES=6 and MIN_SWAP_BYTES=12.
REQ-033 The output stage SHALL be one instance of taxi_axis_register (skid type); no other sub-module.

Verification
REQ-034 A 64-byte frame with dst 02:00:00:00:00:01 and src 02:00:00:00:00:02 -> output dst 02:..:02, src 02:..:01, and bytes 12-63 bit-identical.
REQ-035 A 10-byte frame (beat 1 tkeep=8'h03) -> emitted unmodified, stat_short=1, stat_frames=0.
REQ-036 Back-to-back 60-byte frames, tready always 1 -> 8 output beats per frame with no gaps after the first frame.
REQ-037 Random tready at 50% over 1000 frames of 12-9218 bytes -> all frames match the reference swap model and stat_frames=1000.
REQ-038 Beat 1 tlast with tuser=1 on a 16-byte frame -> both output beats carry tuser=1.
REQ-039 rst_n pulsed low during beat 3 of a 256-byte frame -> no further beats of that frame output, and the next frame is swapped correctly.

Source files
------------

// File: rtl/taxi_eth_mac_swap_pkg.sv
// Shared definitions for the MAC address swap block.
//   state_t        : header FSM states (HEAD0, HEAD1, BODY)
//   MAC_BYTES      : bytes in one MAC address
//   MIN_SWAP_BYTES : shortest frame that carries both addresses
//   swap_beat0/1   : byte remapping of the first two 64-bit beats
package taxi_eth_mac_swap_pkg;

  typedef enum logic [1:0] {HEAD0, HEAD1, BODY} state_t;

  localparam int unsigned MAC_BYTES      = 6;
  localparam int unsigned MIN_SWAP_BYTES = 12;
  localparam int unsigned BEAT_BYTES     = 8;
  // Low tkeep bits of beat 1 that must be set for the source MAC to be complete.
  localparam int unsigned BEAT1_NEED     = MIN_SWAP_BYTES - BEAT_BYTES;

  // Out bytes 0-5 = in bytes 6-11, out bytes 6-7 = in bytes 0-1.
  function automatic logic [63:0] swap_beat0(logic [63:0] b0, logic [63:0] b1);
    return {b0[15:0], b1[31:0], b0[63:MAC_BYTES*8]};
  endfunction

  // Out bytes 0-3 = in bytes 2-5, out bytes 4-7 unchanged.
  function automatic logic [63:0] swap_beat1(logic [63:0] b0, logic [63:0] b1);
    return {b1[63:32], b0[MAC_BYTES*8-1:16]};
  endfunction

endpackage

// File: rtl/taxi_axis_register.sv
// Two-entry skid register for a flattened AXI-stream payload.
// Fully registered in both directions: m_data/m_valid come from flops and
// s_ready is the inverse of the skid-occupied flag.
//   clk, rst_n              : clock, async active-low reset
//   s_data/s_valid/s_ready  : upstream handshake
//   m_data/m_valid/m_ready  : downstream handshake
module taxi_axis_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] m_data_q, skid_data_q;
  logic             m_valid_q, skid_valid_q;

  assign s_ready = !skid_valid_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else if (m_ready || !m_valid_q) begin
      if (skid_valid_q) begin
        m_data_q     <= skid_data_q;
        m_valid_q    <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        m_valid_q <= s_valid;
        if (s_valid) m_data_q <= s_data;
      end
    end else if (s_valid && !skid_valid_q) begin
      // Output stalled: park the in-flight beat.
      skid_data_q  <= s_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/taxi_eth_mac_swap.sv
// Swaps destination and source MAC addresses of Ethernet frames on a
// 64-bit AXI stream. Beat 0 is held until beat 1 arrives, then both are
// remapped; frames shorter than 12 bytes pass unmodified. The hold register
// doubles as a one-beat pipeline stage so the held-beat bubble is absorbed.
// Optional statistics: define TAXI_ETH_MAC_SWAP_STAT_EN to add stat_frames
// (swapped frames) and stat_short (unmodified short frames).
//   clk, rst_n    : clock, async active-low reset
//   s_axis_*      : frames in (tdata, tkeep, tvalid, tready, tlast, tid, tuser)
//   m_axis_*      : frames out, registered through a skid stage
module taxi_eth_mac_swap
  import taxi_eth_mac_swap_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef TAXI_ETH_MAC_SWAP_STAT_EN
  output logic [31:0]         stat_frames,
  output logic [31:0]         stat_short,
`endif
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic [ID_W-1:0]     s_axis_tid,
  input  logic [USER_W-1:0]   s_axis_tuser,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [ID_W-1:0]     m_axis_tid,
  output logic [USER_W-1:0]   m_axis_tuser
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PL_W   = DATA_W + KEEP_W + 1 + ID_W + USER_W;

  if (DATA_W != 64) begin : g_bad_width
    $error("taxi_eth_mac_swap: DATA_W must be 64");
  end

  state_t              state_q, state_d;
  logic                active_q;
  logic                hold_valid_q, hold_valid_d;
  logic                hold_rdy_q, hold_rdy_d;    // held beat may leave without beat 1
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [KEEP_W-1:0]   hold_keep_q, hold_keep_d;
  logic                hold_last_q, hold_last_d;
  logic [ID_W-1:0]     hold_id_q, hold_id_d;
  logic [USER_W-1:0]   hold_user_q, hold_user_d;

  logic                is_head1, beat1_short, s_fire, emit, reg_ready;
  logic [DATA_W-1:0]   emit_data;
  logic [USER_W-1:0]   emit_user;
  logic [PL_W-1:0]     emit_pl, m_pl;

  always_comb begin
    is_head1    = (state_q == HEAD1);
    beat1_short = ~&s_axis_tkeep[BEAT1_NEED-1:0];
    // In HEAD1 the held beat 0 leaves together with the arriving beat 1.
    emit          = hold_valid_q && reg_ready && (hold_rdy_q || (is_head1 && s_axis_tvalid));
    s_axis_tready = active_q && (!hold_valid_q || (reg_ready && (hold_rdy_q || is_head1)));
    s_fire        = s_axis_tvalid && s_axis_tready;

    emit_data = hold_data_q;
    emit_user = hold_user_q;
    if (is_head1) begin
      if (!beat1_short) emit_data = swap_beat0(hold_data_q, s_axis_tdata);
      // Two-beat frame: the bad-frame mark on tlast must also reach beat 0.
      if (s_axis_tlast) emit_user = s_axis_tuser;
    end
    emit_pl = {emit_data, hold_keep_q, hold_last_q, hold_id_q, emit_user};

    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_rdy_d   = hold_rdy_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    hold_id_d    = hold_id_q;
    hold_user_d  = hold_user_q;

    if (s_fire) begin
      hold_valid_d = 1'b1;
      hold_rdy_d   = 1'b1;
      hold_data_d  = s_axis_tdata;
      hold_keep_d  = s_axis_tkeep;
      hold_last_d  = s_axis_tlast;
      hold_id_d    = s_axis_tid;
      hold_user_d  = s_axis_tuser;
      unique case (state_q)
        HEAD0: begin
          hold_rdy_d = s_axis_tlast;
          state_d    = s_axis_tlast ? HEAD0 : HEAD1;
        end
        HEAD1: begin
          if (!beat1_short) hold_data_d = swap_beat1(hold_data_q, s_axis_tdata);
          state_d = s_axis_tlast ? HEAD0 : BODY;
        end
        BODY:    state_d = s_axis_tlast ? HEAD0 : BODY;
        default: state_d = HEAD0;
      endcase
    end else if (emit) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HEAD0;
      active_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_rdy_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_id_q    <= '0;
      hold_user_q  <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      hold_valid_q <= hold_valid_d;
      hold_rdy_q   <= hold_rdy_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      hold_id_q    <= hold_id_d;
      hold_user_q  <= hold_user_d;
    end
  end

  taxi_axis_register #(
    .WIDTH(PL_W)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (emit_pl),
    .s_valid(emit),
    .s_ready(reg_ready),
    .m_data (m_pl),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = m_pl;

`ifdef TAXI_ETH_MAC_SWAP_STAT_EN
  logic        frame_short_q, frame_short;
  logic [31:0] stat_frames_q, stat_short_q;

  always_comb begin
    unique case (state_q)
      HEAD0:   frame_short = 1'b1;
      HEAD1:   frame_short = beat1_short;
      default: frame_short = frame_short_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_short_q <= 1'b0;
      stat_frames_q <= '0;
      stat_short_q  <= '0;
    end else if (s_fire) begin
      if (is_head1) frame_short_q <= beat1_short;
      if (s_axis_tlast) begin
        if (frame_short) stat_short_q  <= stat_short_q + 32'd1;
        else             stat_frames_q <= stat_frames_q + 32'd1;
      end
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_short  = stat_short_q;
`endif

endmodule
